// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access sequencer: word/index widths,
// FSM state encoding and the index of the hard-wired-zero register.
package regfile_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] R0_ADDR = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    HOLD   = 3'd3,
    WRITE  = 3'd4
  } state_t;
endpackage

// File: rtl/regfile_access_seq_if.sv
// Bundle of fetch, write-back, register-file and operand signals around the sequencer.
// Valid/ready: a transfer happens on a rising clock edge where both are high; the
// sender holds valid and payload stable until that edge.
interface regfile_access_seq_if;
  import regfile_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              need_rt;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] rf_address;
  logic              rf_we;
  logic [DATA_W-1:0] rf_d;
  logic [DATA_W-1:0] rf_out;
  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  state_t            dbg_state;

  modport slave (
    input  req_valid, rs_addr, rt_addr, need_rt,
    input  wb_valid, wb_addr, wb_data,
    input  rf_out, op_ready,
    output req_ready, wb_ready,
    output rf_address, rf_we, rf_d,
    output op_valid, op_a, op_b, dbg_state
  );

  modport master (
    output req_valid, rs_addr, rt_addr, need_rt,
    output wb_valid, wb_addr, wb_data,
    output rf_out, op_ready,
    input  req_ready, wb_ready,
    input  rf_address, rf_we, rf_d,
    input  op_valid, op_a, op_b, dbg_state
  );
endinterface

// File: rtl/regfile_access_seq.sv
// Serialises operand fetches and write-backs onto the single register-file port.
// Optional macro REGFILE_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_access_seq
  import regfile_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  regfile_access_seq_if.slave   bus
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rs_q, rs_d;
  logic [ADDR_W-1:0] rt_q, rt_d;
  logic              need_rt_q, need_rt_d;
  logic [ADDR_W-1:0] rf_address_q, rf_address_d;
  logic              rf_we_q, rf_we_d;
  logic [DATA_W-1:0] rf_d_q, rf_d_d;
  logic              op_valid_q, op_valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;

  // Port outputs are registered on the transition into the state that uses them,
  // so rf_address/rf_we/rf_d are already correct for the whole READ/WRITE cycle.
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    need_rt_d    = need_rt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rf_address_d = '0;
    rf_we_d      = 1'b0;
    rf_d_d       = '0;
    op_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.wb_valid) begin
          state_d      = WRITE;
          rf_address_d = bus.wb_addr;
          rf_d_d       = bus.wb_data;
          rf_we_d      = !(R0_ZERO && (bus.wb_addr == R0_ADDR));
        end else if (bus.req_valid) begin
          state_d      = READ_A;
          rs_d         = bus.rs_addr;
          rt_d         = bus.rt_addr;
          need_rt_d    = bus.need_rt;
          rf_address_d = bus.rs_addr;
        end
      end
      READ_A: begin
        op_a_d = (R0_ZERO && (rs_q == R0_ADDR)) ? '0 : bus.rf_out;
        if (need_rt_q) begin
          state_d      = READ_B;
          rf_address_d = rt_q;
        end else begin
          state_d = HOLD;
          op_b_d  = '0;
        end
      end
      READ_B: begin
        op_b_d  = (R0_ZERO && (rt_q == R0_ADDR)) ? '0 : bus.rf_out;
        state_d = HOLD;
      end
      HOLD: begin
        // op_valid is raised one cycle after entering HOLD, from registered operands.
        if (op_valid_q && bus.op_ready) begin
          state_d = IDLE;
        end else begin
          op_valid_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rs_q         <= '0;
      rt_q         <= '0;
      need_rt_q    <= 1'b0;
      rf_address_q <= '0;
      rf_we_q      <= 1'b0;
      rf_d_q       <= '0;
      op_valid_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      state_q      <= state_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      need_rt_q    <= need_rt_d;
      rf_address_q <= rf_address_d;
      rf_we_q      <= rf_we_d;
      rf_d_q       <= rf_d_d;
      op_valid_q   <= op_valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
    end
  end

  assign bus.wb_ready   = (state_q == IDLE);
  assign bus.req_ready  = (state_q == IDLE) && !bus.wb_valid;
  assign bus.rf_address = rf_address_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_d       = rf_d_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.op_a       = op_a_q;
  assign bus.op_b       = op_b_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_access_seq.sv
// Directed bench for regfile_access_seq with a register-file model and an operand scoreboard.
module tb_regfile_access_seq;
  import regfile_pkg::*;

  logic clock;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  regfile_access_seq_if bus ();

  regfile_access_seq dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // register-file model: combinational read, write on rising edge
  function automatic logic [DATA_W-1:0] init_val(int i);
    case (i)
      0:       return 8'h5A;
      2:       return 8'h11;
      5:       return 8'h3C;
      default: return 8'(i * 16 + i);
    endcase
  endfunction

  logic [DATA_W-1:0] mem [2**ADDR_W];
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= init_val(i);
    end else if (bus.rf_we) begin
      mem[bus.rf_address] <= bus.rf_d;
    end
  end
  assign bus.rf_out = mem[bus.rf_address];

  // scoreboard
  logic [DATA_W-1:0] ref_mem [2**ADDR_W];
  logic [2*DATA_W-1:0] exp_q[$];

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] rd_exp(logic [ADDR_W-1:0] a);
    if (R0_ZERO && a == R0_ADDR) return '0;
    return ref_mem[a];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_wb(logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    logic exp_we;
    exp_we = !(R0_ZERO && a == R0_ADDR);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = a;
    bus.wb_data  = d;
    #1;
    chk("wb_ready_idle", 32'(bus.wb_ready), 32'd1);
    step();
    bus.wb_valid = 1'b0;
    chk("wb_state_write", 32'(bus.dbg_state), 32'(WRITE));
    chk("wb_rf_we", 32'(bus.rf_we), 32'(exp_we));
    chk("wb_rf_address", 32'(bus.rf_address), 32'(a));
    chk("wb_rf_d", 32'(bus.rf_d), 32'(d));
    chk("wb_req_ready_busy", 32'(bus.req_ready), 32'd0);
    if (exp_we) ref_mem[a] = d;
    step();
    chk("wb_we_one_cycle", 32'(bus.rf_we), 32'd0);
    chk("wb_back_idle", 32'(bus.dbg_state), 32'(IDLE));
  endtask

  task automatic do_fetch(logic [ADDR_W-1:0] rs, logic [ADDR_W-1:0] rt, logic need,
                          int lat, int hold);
    int n;
    logic [2*DATA_W-1:0] e;
    bus.req_valid = 1'b1;
    bus.rs_addr   = rs;
    bus.rt_addr   = rt;
    bus.need_rt   = need;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
    exp_q.push_back({rd_exp(rs), need ? rd_exp(rt) : 8'h00});
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.op_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    chk("op_valid_latency", 32'(n), 32'(lat));
    bus.op_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_op_valid", 32'(bus.op_valid), 32'd1);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_op_a", 32'(bus.op_a), 32'(exp_q[0][15:8]));
      chk("hold_op_b", 32'(bus.op_b), 32'(exp_q[0][7:0]));
      step();
    end
    bus.op_ready = 1'b1;
    e = exp_q.pop_front();
    chk("op_a", 32'(bus.op_a), 32'(e[15:8]));
    chk("op_b", 32'(bus.op_b), 32'(e[7:0]));
    step();
    bus.op_ready = 1'b0;
    chk("op_valid_drop", 32'(bus.op_valid), 32'd0);
    chk("after_op_idle", 32'(bus.dbg_state), 32'(IDLE));
    chk("after_op_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  // directed sequence
  initial begin
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.rs_addr   = '0;
    bus.rt_addr   = '0;
    bus.need_rt   = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.op_ready  = 1'b0;
    for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = init_val(i);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_op_a", 32'(bus.op_a), 32'd0);
    chk("rst_op_b", 32'(bus.op_b), 32'd0);
    chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("rst_rf_address", 32'(bus.rf_address), 32'd0);
    chk("rst_rf_d", 32'(bus.rf_d), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
    resetn = 1'b1;
    step();

    // reset in the middle of READ_B aborts immediately
    bus.req_valid = 1'b1;
    bus.rs_addr   = 3'd5;
    bus.rt_addr   = 3'd2;
    bus.need_rt   = 1'b1;
    step();
    bus.req_valid = 1'b0;
    chk("mid_read_a_state", 32'(bus.dbg_state), 32'(READ_A));
    chk("mid_read_a_addr", 32'(bus.rf_address), 32'd5);
    step();
    chk("mid_read_b_state", 32'(bus.dbg_state), 32'(READ_B));
    chk("mid_read_b_addr", 32'(bus.rf_address), 32'd2);
    chk("mid_read_b_op_a", 32'(bus.op_a), 32'h3C);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("async_rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("async_rst_rf_address", 32'(bus.rf_address), 32'd0);
    chk("async_rst_op_a", 32'(bus.op_a), 32'd0);
    chk("async_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    #1;
    resetn = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    step();

    // write then two-operand fetch
    do_wb(3'd3, 8'hA5);
    do_fetch(3'd3, 3'd5, 1'b1, 3, 0);

    // single operand
    do_fetch(3'd2, 3'd0, 1'b0, 2, 0);

    // backpressure
    do_fetch(3'd5, 3'd2, 1'b1, 3, 4);

    // collision: write first, fetch held off
    bus.wb_valid  = 1'b1;
    bus.wb_addr   = 3'd1;
    bus.wb_data   = 8'h7E;
    bus.req_valid = 1'b1;
    bus.rs_addr   = 3'd1;
    bus.rt_addr   = 3'd0;
    bus.need_rt   = 1'b0;
    #1;
    chk("coll_req_ready", 32'(bus.req_ready), 32'd0);
    chk("coll_wb_ready", 32'(bus.wb_ready), 32'd1);
    step();
    bus.wb_valid = 1'b0;
    ref_mem[1] = 8'h7E;
    chk("coll_state_write", 32'(bus.dbg_state), 32'(WRITE));
    chk("coll_rf_we", 32'(bus.rf_we), 32'd1);
    chk("coll_rf_address", 32'(bus.rf_address), 32'd1);
    chk("coll_rf_d", 32'(bus.rf_d), 32'h7E);
    do_fetch(3'd1, 3'd0, 1'b0, 2, 0);

    // register 0 behaviour, rs == rt
    do_wb(3'd0, 8'hFF);
    do_fetch(3'd0, 3'd0, 1'b1, 3, 1);
    chk("r0_model_value", 32'(mem[0]), R0_ZERO ? 32'h5A : 32'hFF);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
